alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single combinational ALU between NREQ requesters, for example the core sequencer and the I/O/debug unit.
- Each requester issues one operation (unit select, op select, two 8-bit operands) over a valid/ready handshake.
- The arbiter grants round-robin, registers the operands, drives the ALU for one cycle, captures the result and returns it over a per-requester valid/ready response channel.
- Sits between the requesters and the ALU's unit_sel/op_sel/acc/src inputs and its result output.

Parameters:
NREQ, 2, number of requesters; legal range 2..4.
IDW, $clog2(NREQ), derived width of the grant index; not overridable.

Ports:
clk_in  input  1  clock; all state updates on the rising edge.
rst_in  input  1  synchronous, active-high reset.
req_valid_in  input  NREQ  per-requester request valid.
req_ready_out  output  NREQ  per-requester accept strobe; at most one bit high.
req_unit_sel_in  input  3*NREQ  unit select, slice i for requester i.
req_op_sel_in  input  NREQ  op select (sub / nand / right shift).
req_acc_in  input  8*NREQ  accumulator operand.
req_src_in  input  8*NREQ  source operand.
rsp_valid_out  output  NREQ  per-requester response valid; at most one bit high.
rsp_ready_in  input  NREQ  per-requester response ready.
rsp_data_out  output  8  result, shared by all requesters; qualified by rsp_valid_out.
alu_unit_sel_out  output  3  to ALU.
alu_op_sel_out  output  1  to ALU.
alu_acc_out  output  8  to ALU.
alu_src_out  output  8  to ALU.
alu_res_in  input  8  from ALU, combinational result.
busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst_in high at an edge) values:
  - state = IDLE, rr pointer = 0, grant = 0, result register = 0.
  - All operand registers = 0.
  - All outputs 0.
- Reset has priority over every other event. Reset in EXEC or RESP abandons the transaction: no response is issued and the result is lost.
- IDLE:
  - Picker scans req_valid_in starting at the rr pointer, wrapping modulo NREQ.
  - If any request is valid: req_ready_out[winner] = 1 in the same cycle (combinational from valid and state).
  - At the edge: latch the winner's unit_sel, op_sel, acc and src into registers, store grant = winner, go to EXEC.
  - If no request is valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - ALU outputs are driven from the operand registers.
  - At the edge: result register <= alu_res_in, go to RESP.
- RESP:
  - rsp_valid_out[grant] = 1 and rsp_data_out = result register.
  - Stay in RESP while rsp_ready_in[grant] = 0. Data is held stable.
  - On handshake: rr pointer <= (grant+1) mod NREQ, go to IDLE.
  - rsp_ready_in bits of non-granted requesters are ignored.
- Outside EXEC, the alu_*_out ports are 0, so unit 000 computes 0+0 and nothing toggles needlessly.
- rsp_data_out is 0 when no rsp_valid_out bit is high.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid at T+2.
  - Back-to-back throughput is 1 op per 3 cycles with rsp_ready held high.
- Handshake rules for requesters:
  - Once req_valid_in is asserted, it stays high with stable operands until accepted.
  - A requester may assert a new request while its previous response is pending. The request is not accepted until the arbiter returns to IDLE.
- All 8 unit-select codes are forwarded unmodified. Arithmetic width and overflow behaviour belong to the ALU. Code 110 (multiply) returns the low 8 bits as the ALU produces them.
- Simultaneous requests: the winner is the first valid index at or after the rr pointer. After completion the pointer moves past the winner, so no requester starves.

Optional Feature:
ALU_ARB_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins. The rr pointer is not implemented, so its reset and update logic are absent.
- Undefined: round-robin as described above.
- Everything else is identical in both builds.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP} (2 bits);
  - unit-select constants UNIT_ADD=000, UNIT_AND=001, UNIT_SHIFT=010, UNIT_MOV=011, UNIT_OR=100, UNIT_XOR=101, UNIT_MUL=110, UNIT_PASS=111.
- One sub-module: rr_picker. Inputs: valid vector and start pointer. Outputs: one-hot grant, grant index, any-valid.
  - Purely combinational.
  - The ALU_ARB_PRIO_EN build ties its start pointer to 0.

Test Plan:
- Add: req0 with unit 000, op 0, acc 0x05, src 0x03, rsp_ready held high.
  - req_ready_out=01 at T; alu outputs 000/0/05/03 at T+1; rsp_valid_out=01 with rsp_data_out=0x08 at T+2; busy_out back to 0 at T+3.
- Subtract: req1 with unit 000, op 1, acc 0x10, src 0x01 -> rsp_valid_out=10 with rsp_data_out=0x0F.
- Contention, round-robin build: both requesters valid continuously from reset, each with unit 011 and src 0xA0 (req0) / 0xB0 (req1).
  - Grants occur in order 0,1,0,1.
  - Responses are A0,B0,A0,B0, with one response every 3 cycles.
- Contention, ALU_ARB_PRIO_EN build: same stimulus -> req0 is granted every time and req1 is never granted.
- Backpressure: a shift request (unit 010, op 1, acc 0x80, src 0x03) with rsp_ready low for 5 cycles.
  - rsp_valid_out and rsp_data_out=0x10 are held for 5 cycles with no change.
  - A pending req1 is not accepted during this time, and is accepted the cycle after the handshake.
- Reset mid-operation: assert rst_in during EXEC.
  - Next cycle: all outputs 0 and state IDLE.
  - No response is ever issued.
  - The requester's next request starts at the rr pointer position 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and ALU unit-select codes for the ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int UNIT_W = 3;
  localparam int DATA_W = 8;

  localparam logic [UNIT_W-1:0] UNIT_ADD   = 3'b000;
  localparam logic [UNIT_W-1:0] UNIT_AND   = 3'b001;
  localparam logic [UNIT_W-1:0] UNIT_SHIFT = 3'b010;
  localparam logic [UNIT_W-1:0] UNIT_MOV   = 3'b011;
  localparam logic [UNIT_W-1:0] UNIT_OR    = 3'b100;
  localparam logic [UNIT_W-1:0] UNIT_XOR   = 3'b101;
  localparam logic [UNIT_W-1:0] UNIT_MUL   = 3'b110;
  localparam logic [UNIT_W-1:0] UNIT_PASS  = 3'b111;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational rotating picker: first valid index at or after start_in, wrapping modulo NREQ.
// With ALU_ARB_PRIO_EN the parent ties start_in to 0, giving fixed lowest-index priority.
module rr_picker
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_in,
  input  logic [IDW-1:0]  start_in,
  output logic [NREQ-1:0] grant_oh_out,
  output logic [IDW-1:0]  grant_idx_out,
  output logic            any_valid_out
);

  logic [NREQ-1:0] rot_s;
  logic [IDW:0]    sum_s;

  // Rotate the valid vector so bit k is requester (start+k) mod NREQ, then pick the lowest k.
  always_comb begin
    rot_s         = NREQ'({valid_in, valid_in} >> start_in);
    grant_idx_out = '0;
    sum_s         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum_s         = {1'b0, start_in} + (IDW+1)'(k);
      sum_s         = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
      grant_idx_out = rot_s[k] ? sum_s[IDW-1:0] : grant_idx_out;
    end
    any_valid_out = |rot_s;
    grant_oh_out  = '0;
    for (int j = 0; j < NREQ; j++) begin
      grant_oh_out[j] = any_valid_out && (grant_idx_out == IDW'(j));
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters: accept, execute for one cycle, respond.
// Build option ALU_ARB_PRIO_EN: fixed lowest-index priority instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NREQ-1:0]          req_valid_in,
  output logic [NREQ-1:0]          req_ready_out,
  input  logic [UNIT_W*NREQ-1:0]   req_unit_sel_in,
  input  logic [NREQ-1:0]          req_op_sel_in,
  input  logic [DATA_W*NREQ-1:0]   req_acc_in,
  input  logic [DATA_W*NREQ-1:0]   req_src_in,
  output logic [NREQ-1:0]          rsp_valid_out,
  input  logic [NREQ-1:0]          rsp_ready_in,
  output logic [DATA_W-1:0]        rsp_data_out,
  output logic [UNIT_W-1:0]        alu_unit_sel_out,
  output logic                     alu_op_sel_out,
  output logic [DATA_W-1:0]        alu_acc_out,
  output logic [DATA_W-1:0]        alu_src_out,
  input  logic [DATA_W-1:0]        alu_res_in,
  output logic                     busy_out
);

  state_e            state_q,  state_d;
  logic [IDW-1:0]    grant_q,  grant_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [UNIT_W-1:0] unit_q,   unit_d;
  logic              op_q,     op_d;
  logic [DATA_W-1:0] acc_q,    acc_d;
  logic [DATA_W-1:0] src_q,    src_d;

  logic [IDW-1:0]    start_s;
  logic [NREQ-1:0]   pick_oh_s;
  logic [IDW-1:0]    pick_idx_s;
  logic              pick_any_s;
  logic [NREQ-1:0]   gnt_oh_s;
  logic              rsp_hs_s;
  logic [UNIT_W-1:0] sel_unit_s;
  logic              sel_op_s;
  logic [DATA_W-1:0] sel_acc_s;
  logic [DATA_W-1:0] sel_src_s;

`ifdef ALU_ARB_PRIO_EN
  assign start_s = '0;
`else
  logic [IDW-1:0] rr_q, rr_d;
  assign start_s = rr_q;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .valid_in      (req_valid_in),
    .start_in      (start_s),
    .grant_oh_out  (pick_oh_s),
    .grant_idx_out (pick_idx_s),
    .any_valid_out (pick_any_s)
  );

  // Winner operand mux and granted-requester decode for the response channel.
  always_comb begin
    sel_unit_s = '0;
    sel_op_s   = 1'b0;
    sel_acc_s  = '0;
    sel_src_s  = '0;
    gnt_oh_s   = '0;
    for (int j = 0; j < NREQ; j++) begin
      sel_unit_s  = sel_unit_s | ({UNIT_W{pick_oh_s[j]}} & req_unit_sel_in[j*UNIT_W +: UNIT_W]);
      sel_op_s    = sel_op_s | (pick_oh_s[j] & req_op_sel_in[j]);
      sel_acc_s   = sel_acc_s | ({DATA_W{pick_oh_s[j]}} & req_acc_in[j*DATA_W +: DATA_W]);
      sel_src_s   = sel_src_s | ({DATA_W{pick_oh_s[j]}} & req_src_in[j*DATA_W +: DATA_W]);
      gnt_oh_s[j] = (grant_q == IDW'(j));
    end
    rsp_hs_s = |(gnt_oh_s & rsp_ready_in);
  end

  // Next-state and register-load decisions.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    result_d = result_q;
    unit_d   = unit_q;
    op_d     = op_q;
    acc_d    = acc_q;
    src_d    = src_q;
`ifndef ALU_ARB_PRIO_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = EXEC;
          grant_d = pick_idx_s;
          unit_d  = sel_unit_s;
          op_d    = sel_op_s;
          acc_d   = sel_acc_s;
          src_d   = sel_src_s;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d = alu_res_in;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_d = IDLE;
`ifndef ALU_ARB_PRIO_EN
          // Move past the winner so the other requesters get the next turn.
          rr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : (grant_q + IDW'(1));
`endif
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      result_q <= '0;
      unit_q   <= '0;
      op_q     <= 1'b0;
      acc_q    <= '0;
      src_q    <= '0;
`ifndef ALU_ARB_PRIO_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      result_q <= result_d;
      unit_q   <= unit_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      src_q    <= src_d;
`ifndef ALU_ARB_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Outputs decoded from state; the ALU sees zeros except during EXEC.
  always_comb begin
    req_ready_out    = '0;
    rsp_valid_out    = '0;
    rsp_data_out     = '0;
    alu_unit_sel_out = UNIT_ADD;
    alu_op_sel_out   = 1'b0;
    alu_acc_out      = '0;
    alu_src_out      = '0;
    case (state_q)
      IDLE: begin
        req_ready_out = pick_oh_s;
      end
      EXEC: begin
        alu_unit_sel_out = unit_q;
        alu_op_sel_out   = op_q;
        alu_acc_out      = acc_q;
        alu_src_out      = src_q;
      end
      RESP: begin
        rsp_valid_out = gnt_oh_s;
        rsp_data_out  = result_q;
      end
      default: begin
        req_ready_out = '0;
      end
    endcase
    busy_out = (state_q != IDLE);
  end

endmodule
